// File: rtl/top_pkg.sv
// Shared definitions for the press-counter / stopwatch display top.
// Holds the default cycle counts, the BCD digit type and the 7-segment
// decode (active-low segments, [0]=a .. [6]=g, [7]=dp, dp always off).
package top_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;  // 20 ms at 100 MHz
  localparam int TICK_CYCLES_DEF     = 1_000_000;  // 10 ms at 100 MHz
  localparam int SCAN_CYCLES_DEF     = 100_000;    // 1 ms at 100 MHz

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic logic [7:0] seg7(input bcd_t d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/top_debouncer.sv
// Button conditioning: 2-FF synchroniser, stability counter and a
// one-cycle pulse on the 0->1 edge of the debounced level.
// Ports:
//   clk      system clock
//   i_rst    synchronous active-high reset
//   i_raw    raw asynchronous button level
//   o_press  one-cycle pulse when the debounced level rises
module top_debouncer #(
  parameter int CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          r_s1, r_s2;
  logic          r_db, r_db_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      // Count consecutive cycles of disagreement; any agreement restarts.
      if (r_s2 != r_db) begin
        if (r_cnt == CW'(CYCLES - 1)) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_db & ~r_db_q;

endmodule

// File: rtl/top.sv
// Board top: press counter (digits 7..6, 00..99) and a 6-digit decimal
// stopwatch (digits 5..0) on an 8-digit multiplexed 7-segment display.
// Ports:
//   clk                system clock (100 MHz)
//   button_reset       synchronous active-high reset, used undebounced
//   button_start_stop  raw start/stop button (toggles running)
//   button_count       raw count button (press count +1)
//   global_led_en      display master enable, 1 = on
//   led_en[7:0]        digit enables, active-low one-hot
//   led_cx[7:0]        segments, active-low, [7]=dp
module top
  import top_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TICK_CYCLES     = TICK_CYCLES_DEF,
  parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       button_reset,
  input  logic       button_start_stop,
  input  logic       button_count,
  input  logic       global_led_en,
  output logic [7:0] led_en,
  output logic [7:0] led_cx
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  // CLK_HZ only documents the clock the cycle counts were sized for.
  logic w_unused_clk_hz;
  assign w_unused_clk_hz = ^CLK_HZ;

  logic w_ss_press, w_cnt_press;

  top_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk     (clk),
    .i_rst   (button_reset),
    .i_raw   (button_start_stop),
    .o_press (w_ss_press)
  );

  top_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_cnt (
    .clk     (clk),
    .i_rst   (button_reset),
    .i_raw   (button_count),
    .o_press (w_cnt_press)
  );

  bcd_t [1:0]    r_pc;    // press count, [1] = tens
  bcd_t [5:0]    r_rc;    // run count, [0] = units
  logic          r_run;
  logic [TW-1:0] r_tick;
  logic [SW-1:0] r_scan;
  logic [2:0]    r_idx;

  // Ripple BCD increment; the final carry out is the natural wrap to zero.
  bcd_t [1:0] w_pc_inc;
  bcd_t [5:0] w_rc_inc;
  logic       w_pc_c, w_rc_c;

  always_comb begin
    w_pc_inc = r_pc;
    w_pc_c   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (w_pc_c) begin
        if (r_pc[i] == 4'd9) begin
          w_pc_inc[i] = 4'd0;
        end else begin
          w_pc_inc[i] = r_pc[i] + 4'd1;
          w_pc_c      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_rc_inc = r_rc;
    w_rc_c   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (w_rc_c) begin
        if (r_rc[i] == 4'd9) begin
          w_rc_inc[i] = 4'd0;
        end else begin
          w_rc_inc[i] = r_rc[i] + 4'd1;
          w_rc_c      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (button_reset) begin
      r_pc   <= '0;
      r_rc   <= '0;
      r_run  <= 1'b0;
      r_tick <= '0;
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      if (w_cnt_press) r_pc <= w_pc_inc;

      // A start/stop press wins over a coincident tick, so a stop never
      // lets through a final increment.
      if (w_ss_press) begin
        r_run  <= ~r_run;
        r_tick <= '0;
      end else if (r_run) begin
        if (r_tick == TW'(TICK_CYCLES - 1)) begin
          r_tick <= '0;
          r_rc   <= w_rc_inc;
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end

      // Scan keeps running even when the display is disabled.
      if (r_scan == SW'(SCAN_CYCLES - 1)) begin
        r_scan <= '0;
        r_idx  <= r_idx + 3'd1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
    end
  end

  bcd_t [7:0] w_dig;
  assign w_dig = {r_pc, r_rc};

  always_comb begin
    led_en = 8'hFF;
    led_cx = SEG_OFF;
    if (global_led_en) begin
      led_en = ~(8'd1 << r_idx);
      led_cx = seg7(w_dig[r_idx]);
    end
  end

endmodule

// File: tb/tb_top.sv
module tb_top;

  localparam int DB = 5;
  localparam int TK = 3;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic btn_rst, btn_ss, btn_cnt, gle;
  logic [7:0] led_en, led_cx;

  always #5 clk = ~clk;

  top #(
    .CLK_HZ          (100_000_000),
    .DEBOUNCE_CYCLES (DB),
    .TICK_CYCLES     (TK),
    .SCAN_CYCLES     (SC)
  ) dut (
    .clk               (clk),
    .button_reset      (btn_rst),
    .button_start_stop (btn_ss),
    .button_count      (btn_cnt),
    .global_led_en     (gle),
    .led_en            (led_en),
    .led_cx            (led_cx)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int p10 [6] = '{1, 10, 100, 1000, 10000, 100000};

  // ---------------- reference model (index 0 = start/stop, 1 = count) ---
  int m_s1 [2], m_s2 [2], m_db [2], m_prev [2], m_cnt [2];
  int m_pc = 0, m_rc = 0, m_run = 0, m_tick = 0, m_cyc = 0;

  always @(posedge clk) begin
    int raw [2];
    int nd;
    bit p_ss, p_cnt;
    raw[0] = int'(btn_ss);
    raw[1] = int'(btn_cnt);
    if (btn_rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_prev[b] = 0; m_cnt[b] = 0;
      end
      m_pc = 0; m_rc = 0; m_run = 0; m_tick = 0; m_cyc = 0;
    end else begin
      p_ss  = (m_db[0] == 1) && (m_prev[0] == 0);
      p_cnt = (m_db[1] == 1) && (m_prev[1] == 0);
      if (p_cnt) m_pc = (m_pc + 1) % 100;
      if (p_ss) begin
        m_run  = 1 - m_run;
        m_tick = 0;
      end else if (m_run == 1) begin
        if (m_tick == TK - 1) begin
          m_tick = 0;
          m_rc   = (m_rc + 1) % 1000000;
        end else begin
          m_tick++;
        end
      end
      m_cyc++;
      for (int b = 0; b < 2; b++) begin
        nd = m_db[b];
        if (m_s2[b] != m_db[b]) begin
          m_cnt[b]++;
          if (m_cnt[b] == DB) begin
            nd = m_s2[b];
            m_cnt[b] = 0;
          end
        end else begin
          m_cnt[b] = 0;
        end
        m_prev[b] = m_db[b];
        m_db[b]   = nd;
        m_s2[b]   = m_s1[b];
        m_s1[b]   = raw[b];
      end
    end
  end

  function automatic int model_digit(input int i);
    if (i == 7) return m_pc / 10;
    if (i == 6) return m_pc % 10;
    return (m_rc / p10[i]) % 10;
  endfunction

  // Every cycle: display outputs against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e_en, e_cx, one;
    int idx;
    if (chk_en) begin
      idx = (m_cyc / SC) % 8;
      one = 8'd1;
      if (gle) begin
        e_en = ~(one << idx);
        e_cx = seg_tab[model_digit(idx)];
      end else begin
        e_en = 8'hFF;
        e_cx = 8'hFF;
      end
      chk("led_en", int'(led_en), int'(e_en));
      chk("led_cx", int'(led_cx), int'(e_cx));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit which, input int hold, input int gap);
    if (which) btn_cnt = 1'b1; else btn_ss = 1'b1;
    step(hold);
    if (which) btn_cnt = 1'b0; else btn_ss = 1'b0;
    step(gap);
  endtask

  // Reassemble the displayed digits from one full scan of the outputs.
  task automatic read_disp(output int pc, output int rc);
    int d [8];
    for (int i = 0; i < 8; i++) d[i] = 99;
    for (int k = 0; k < 8 * SC + 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        if (led_en == ~(8'd1 << i))
          for (int v = 0; v < 10; v++)
            if (led_cx == seg_tab[v]) d[i] = v;
    end
    pc = d[7] * 10 + d[6];
    rc = 0;
    for (int i = 0; i < 6; i++) rc += d[i] * p10[i];
  endtask

  int pc, rc, rc_before;

  initial begin
    btn_rst = 1'b1; btn_ss = 1'b0; btn_cnt = 1'b0; gle = 1'b1;
    step(1);
    chk_en = 1'b1;
    step(19);
    btn_rst = 1'b0;
    @(negedge clk);
    chk("rst_en", int'(led_en), 8'hFE);
    chk("rst_cx", int'(led_cx), 8'hC0);
    repeat (SC) @(negedge clk);
    chk("scan1_en", int'(led_en), 8'hFD);
    read_disp(pc, rc);
    chk("rst_pc", pc, 0);
    chk("rst_rc", rc, 0);

    // Two accepted count presses and one too short to be accepted.
    press(1'b1, DB + 3, DB + 6);
    press(1'b1, DB + 3, DB + 6);
    press(1'b1, DB - 2, DB + 6);
    read_disp(pc, rc);
    chk("pc_two", pc, 2);

    // Run for a while, then stop; the count must freeze.
    press(1'b0, DB + 3, 40);
    press(1'b0, DB + 3, DB + 6);
    read_disp(pc, rc);
    chk("run_rc", rc, m_rc);
    chk("run_nz", int'(rc > 5 && rc < 30), 1);
    rc_before = rc;
    step(30);
    read_disp(pc, rc);
    chk("paused_rc", rc, rc_before);

    // Display disabled; per-cycle checks expect all-off.
    gle = 1'b0;
    step(20);
    gle = 1'b1;
    read_disp(pc, rc);
    chk("reen_pc", pc, 2);

    // Presses while paused.
    for (int i = 0; i < 3; i++) press(1'b1, DB + 3, DB + 4);
    read_disp(pc, rc);
    chk("pc_five", pc, 5);
    chk("pc_five_rc", rc, rc_before);

    // 95 more presses wraps 99 -> 00.
    for (int i = 0; i < 95; i++) press(1'b1, DB + 2, DB + 4);
    read_disp(pc, rc);
    chk("pc_wrap", pc, 0);

    // Long run to cross several decimal carries.
    press(1'b0, DB + 3, 3000);
    press(1'b0, DB + 3, DB + 6);
    read_disp(pc, rc);
    chk("long_rc", rc, m_rc);
    chk("long_carry", int'(rc >= 1000), 1);

    // Both buttons pressed together.
    btn_ss = 1'b1; btn_cnt = 1'b1;
    step(DB + 3);
    btn_ss = 1'b0; btn_cnt = 1'b0;
    step(50);
    press(1'b0, DB + 3, DB + 6);
    read_disp(pc, rc);
    chk("both_pc", pc, 1);
    chk("both_rc", rc, m_rc);

    // Mid-operation reset with the count button still held.
    press(1'b0, DB + 3, 10);
    btn_cnt = 1'b1;
    btn_rst = 1'b1;
    step(4);
    btn_rst = 1'b0;
    @(negedge clk);
    chk("mrst_en", int'(led_en), 8'hFE);
    chk("mrst_cx", int'(led_cx), 8'hC0);
    step(DB + 8);
    btn_cnt = 1'b0;
    step(DB + 6);
    read_disp(pc, rc);
    chk("mrst_pc", pc, 1);
    chk("mrst_rc", rc, 0);

    // Random bouncing buttons, display enable and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 8 == 0) btn_ss = ~btn_ss;
      if ($urandom % 8 == 0) btn_cnt = ~btn_cnt;
      if ($urandom % 40 == 0) gle = ~gle;
      if ($urandom % 700 == 0) begin
        btn_rst = 1'b1;
        step(1 + $urandom % 4);
        btn_rst = 1'b0;
      end
      step(1);
    end
    btn_ss = 1'b0; btn_cnt = 1'b0; gle = 1'b1;
    step(DB + 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
